// File: rtl/accel_cfg_pkg.sv
// accel_cfg_pkg: shared field widths, packet layout and FSM state for the config injector
package accel_cfg_pkg;
  localparam int COORD_W = 4;
  localparam int SAMP_W = 4;
  localparam int DES_W = 4;
  localparam int OP_W = 4;
  localparam int DATA_W = 32;
  localparam int ROUTE_W = 20;
  localparam int PKT_W = 64;
  typedef struct packed {
    logic [ROUTE_W-1:0] route;
    logic [SAMP_W-1:0] sampler;
    logic [DES_W-1:0] designator;
    logic [OP_W-1:0] opcode;
    logic [DATA_W-1:0] data;
  } cfg_pkt_t;
  typedef enum logic [1:0] {IDLE, GAP, DRAIN} cfg_state_t;
endpackage

// File: rtl/cfg_route_encoder.sv
// cfg_route_encoder: turns a target (x, y) into an MSB-first hop route and a legality flag
module cfg_route_encoder
  import accel_cfg_pkg::*;
#(
  parameter int COLS = 4,
  parameter int ROWS = 4
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ROUTE_W-1:0] route,
  output logic               legal
);
  logic [COORD_W:0] hops;
  assign hops = {1'b0, x} + {1'b0, y};
  assign legal = (int'(x) < COLS) && (int'(y) < ROWS) && (int'(hops) <= ROUTE_W - 1);
  // east hops are ones, south hops are zeros, then a single terminator one
  always_comb begin
    route = '0;
    for (int p = 0; p < ROUTE_W; p++)
      route[ROUTE_W-1-p] = (p < int'(x)) || (p == int'(hops));
  end
endmodule

// File: rtl/cfg_injector.sv
// cfg_injector: accepts config entries and injects routed packets into the mesh corner switch
module cfg_injector
  import accel_cfg_pkg::*;
#(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  parameter int INJECT_GAP = 2,
  parameter int DRAIN_CYCLES = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic [SAMP_W-1:0]  cfg_sampler,
  input  logic [DES_W-1:0]   cfg_designator,
  input  logic [OP_W-1:0]    cfg_opcode,
  input  logic [DATA_W-1:0]  cfg_data,
  input  logic               cfg_last,
  output logic [PKT_W-1:0]   o_config,
  output logic               load,
  output logic               busy,
  output logic               done,
  output logic               err_route
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  cfg_state_t state;
  logic [ROUTE_W-1:0] route;
  logic legal;
  logic accept;
  logic injected;
  logic [3:0] gap_cnt;
  logic [DW-1:0] drain_cnt;
  cfg_pkt_t pkt;
  cfg_route_encoder #(.COLS(COLS), .ROWS(ROWS)) u_enc (
    .x(cfg_x),
    .y(cfg_y),
    .route(route),
    .legal(legal)
  );
  assign pkt = '{route: route, sampler: cfg_sampler, designator: cfg_designator,
                 opcode: cfg_opcode, data: cfg_data};
  assign cfg_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = cfg_valid && cfg_ready;
  // injection sequencing: one packet per accept, spaced by GAP, load held through DRAIN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      o_config <= '0;
      load <= 1'b0;
      done <= 1'b0;
      err_route <= 1'b0;
      injected <= 1'b0;
      gap_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      o_config <= '0;
      done <= 1'b0;
      err_route <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (legal) begin
            o_config <= pkt;
            load <= 1'b1;
            injected <= 1'b1;
          end else err_route <= 1'b1;
          if (cfg_last) begin
            if (legal || injected) begin
              state <= DRAIN;
              drain_cnt <= '0;
            end else done <= 1'b1;
          end else if (legal && INJECT_GAP > 1) begin
            state <= GAP;
            gap_cnt <= 4'd1;
          end
        end
        GAP: if (gap_cnt == 4'(INJECT_GAP - 1)) state <= IDLE;
             else gap_cnt <= gap_cnt + 4'd1;
        DRAIN: if (drain_cnt == DW'(DRAIN_CYCLES)) begin
          state <= IDLE;
          load <= 1'b0;
          done <= 1'b1;
          injected <= 1'b0;
          drain_cnt <= '0;
        end else drain_cnt <= drain_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cfg_injector.sv
// tb_cfg_injector: table-driven scoreboard bench for cfg_injector
module tb_cfg_injector;
  logic clk = 0;
  logic reset = 1;
  logic cfg_valid = 0;
  logic cfg_ready;
  logic [3:0] cfg_x = 0, cfg_y = 0, cfg_sampler = 0, cfg_designator = 0, cfg_opcode = 0;
  logic [31:0] cfg_data = 0;
  logic cfg_last = 0;
  logic [63:0] o_config;
  logic load, busy, done, err_route;

  cfg_injector #(.COLS(4), .ROWS(4), .INJECT_GAP(2), .DRAIN_CYCLES(48)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_sampler(cfg_sampler), .cfg_designator(cfg_designator),
    .cfg_opcode(cfg_opcode), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .o_config(o_config), .load(load), .busy(busy), .done(done), .err_route(err_route)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x, y, s, d, o;
    logic [31:0] data;
    logic last;
    logic legal;
    logic [19:0] route;
  } row_t;

  row_t tbl[8];
  logic [63:0] q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, errs = 0, dones = 0;
  int acc[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (err_route) errs++;
    if (done) dones++;
    if (o_config != 64'h0) begin
      if (q.size() == 0) check("unexpected_injection", o_config, 64'h0);
      else check("o_config", o_config, q.pop_front());
      check("load_on_inject", {63'b0, load}, 64'd1);
      check("ready_low_on_inject", {63'b0, cfg_ready}, 64'd0);
    end
  endtask

  task automatic send(input row_t r, output int acc_cyc);
    cfg_x = r.x; cfg_y = r.y; cfg_sampler = r.s; cfg_designator = r.d;
    cfg_opcode = r.o; cfg_data = r.data; cfg_last = r.last; cfg_valid = 1;
    for (int k = 0; k < 200 && !cfg_ready; k++) tick();
    if (!cfg_ready) check("ready_timeout", {63'b0, cfg_ready}, 64'd1);
    if (r.legal) q.push_back({r.route, r.s, r.d, r.o, r.data});
    tick();
    acc_cyc = cyc;
    cfg_valid = 0;
    cfg_last = 0;
  endtask

  initial begin
    int hi, d0, e0, a;
    logic ld;
    row_t r;
    tbl[0] = '{4'd2, 4'd1, 4'h3, 4'h1, 4'h5, 32'hDEADBEEF, 1'b0, 1'b1, 20'hD0000};
    tbl[1] = '{4'd0, 4'd0, 4'hA, 4'hB, 4'hC, 32'h12345678, 1'b0, 1'b1, 20'h80000};
    tbl[2] = '{4'd3, 4'd3, 4'h7, 4'h2, 4'h9, 32'hCAFEF00D, 1'b0, 1'b1, 20'hE2000};
    tbl[3] = '{4'd5, 4'd0, 4'h1, 4'h1, 4'h1, 32'h11111111, 1'b0, 1'b0, 20'h00000};
    tbl[4] = '{4'd1, 4'd2, 4'h4, 4'h6, 4'h8, 32'h0000FFFF, 1'b0, 1'b1, 20'h90000};
    tbl[5] = '{4'd0, 4'd4, 4'h2, 4'h2, 4'h2, 32'h22222222, 1'b0, 1'b0, 20'h00000};
    tbl[6] = '{4'd3, 4'd0, 4'hF, 4'hE, 4'hD, 32'h80000001, 1'b0, 1'b1, 20'hF0000};
    tbl[7] = '{4'd0, 4'd3, 4'h0, 4'h5, 4'hA, 32'h00000000, 1'b0, 1'b1, 20'h10000};

    tick(); tick();
    check("rst_o_config", o_config, 64'h0);
    check("rst_load", {63'b0, load}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_err", {63'b0, err_route}, 64'd0);
    check("rst_ready", {63'b0, cfg_ready}, 64'd1);
    reset = 0;
    tick();

    for (int i = 0; i < 8; i++) begin
      ld = load;
      e0 = errs;
      send(tbl[i], acc[i]);
      if (tbl[i].legal) begin
        check($sformatf("row%0d_busy", i), {63'b0, busy}, 64'd1);
        if (i > 0 && tbl[i-1].legal)
          check($sformatf("row%0d_spacing", i), 64'(acc[i] - acc[i-1]), 64'd2);
      end else begin
        check($sformatf("row%0d_err", i), 64'(errs - e0), 64'd1);
        check($sformatf("row%0d_idle", i), {63'b0, busy}, 64'd0);
        check($sformatf("row%0d_load", i), {63'b0, load}, {63'b0, ld});
      end
    end
    tick();
    check("err_total", 64'(errs), 64'd2);
    check("load_held", {63'b0, load}, 64'd1);

    r = '{4'd1, 4'd1, 4'h9, 4'h8, 4'h7, 32'hA5A5A5A5, 1'b1, 1'b1, 20'hA0000};
    d0 = dones;
    send(r, a);
    hi = 0;
    for (int k = 0; k < 48; k++) begin
      tick();
      if (load && !done) hi++;
    end
    check("drain_load_high", 64'(hi), 64'd48);
    tick();
    check("drain_end_load", {63'b0, load}, 64'd0);
    check("drain_done", {63'b0, done}, 64'd1);
    check("drain_idle", {63'b0, busy}, 64'd0);
    tick();
    check("done_one_cycle", 64'(dones - d0), 64'd1);

    send(r, a);
    for (int k = 0; k < 10; k++) tick();
    reset = 1;
    #1;
    check("mid_rst_load", {63'b0, load}, 64'd0);
    check("mid_rst_o_config", o_config, 64'h0);
    check("mid_rst_busy", {63'b0, busy}, 64'd0);
    tick(); tick();
    reset = 0;
    d0 = dones;
    tick();
    check("post_rst_ready", {63'b0, cfg_ready}, 64'd1);
    for (int k = 0; k < 60; k++) tick();
    check("no_done_after_rst", 64'(dones - d0), 64'd0);

    r = '{4'd5, 4'd0, 4'h1, 4'h2, 4'h3, 32'h55555555, 1'b1, 1'b0, 20'h00000};
    send(r, a);
    check("illegal_last_err", {63'b0, err_route}, 64'd1);
    check("illegal_last_done", {63'b0, done}, 64'd1);
    check("illegal_last_load", {63'b0, load}, 64'd0);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (load || busy) hi++;
    end
    check("illegal_last_quiet", 64'(hi), 64'd0);
    check("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cfg_injector.md
CFG_INJECTOR -- requirements
Module: cfg_injector

Interface
REQ-001 SHALL have parameter COLS, default 4: mesh columns (x range 0..COLS-1).
REQ-002 SHALL have parameter ROWS, default 4: mesh rows (y range 0..ROWS-1).
REQ-003 SHALL have parameter INJECT_GAP, default 2: minimum cycles between successive injections, legal range 1..15.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 48: cycles that load stays high after the last injection.
REQ-005 SHALL have port clk  input  1: single clock, rising edge.
REQ-006 SHALL have port reset  input  1: asynchronous, active-high.
REQ-007 SHALL have port cfg_valid  input  1: request entry valid.
REQ-008 SHALL have port cfg_ready  output  1: request entry accepted when high with cfg_valid.
REQ-009 SHALL have ports cfg_x and cfg_y  input  4 each: target column and target row.
REQ-010 SHALL have ports cfg_sampler, cfg_designator and cfg_opcode  input  4 each: port sampler, output designator and PE opcode.
REQ-011 SHALL have port cfg_data  input  32: PE internal data.
REQ-012 SHALL have port cfg_last  input  1: final entry of the program.
REQ-013 SHALL have port o_config  output  64: packet into the north config input of the corner switch.
REQ-014 SHALL have port load  output  1: mesh-wide configuration enable.
REQ-015 SHALL have ports busy, done and err_route  output  1 each: busy = not IDLE; done = 1-cycle pulse; err_route = 1-cycle pulse.

Function
REQ-016 Packet format SHALL be: [63:44] route, [43:40] sampler, [39:36] designator, [35:32] opcode, [31:0] data.
REQ-017 Route SHALL be filled MSB-first as: x ones (east hops), then y zeros (south hops), then a single 1 (terminator), then zeros; x=2,y=1 gives 20'hD0000; x=0,y=0 gives 20'h80000.
REQ-018 An entry SHALL be legal only when x<COLS, y<ROWS and x+y<=19.
REQ-019 FSM states SHALL be IDLE, GAP and DRAIN.
REQ-020 cfg_ready SHALL be high only in IDLE.
REQ-021 Legal accept: the next cycle SHALL drive o_config with the packet for exactly 1 cycle, set load high, and move to GAP (or to DRAIN if cfg_last).
REQ-022 o_config SHALL be 64'h0 in every cycle without an injection.
REQ-023 GAP SHALL last INJECT_GAP cycles counted from the injection cycle, then return to IDLE; load SHALL stay high.
REQ-024 Illegal accept: the entry SHALL be dropped with nothing injected and err_route pulsed next cycle; cfg_last on that entry SHALL still be honoured.
REQ-025 Last entry handling: if any packet was injected since the last done, the FSM SHALL enter DRAIN; otherwise it SHALL pulse done and stay in IDLE.
REQ-026 DRAIN SHALL hold load high for DRAIN_CYCLES cycles after the final injection, then drop load, pulse done for 1 cycle and return to IDLE.
REQ-027 cfg_valid SHALL be ignored outside IDLE.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE with o_config=0, load=0, done=0, err_route=0, busy=0 and all counters at 0.
REQ-029 Reset asserted mid-GAP or mid-DRAIN SHALL abandon the operation with no done pulse.

Structure
REQ-030 Package accel_cfg_pkg SHALL hold: field widths, ROUTE_W=20, the packet struct, and the state enum.
REQ-031 Route construction SHALL be a combinational sub-module cfg_route_encoder (x, y -> 20-bit route plus legal flag).

Verification
REQ-032 x=2,y=1,sampler=4'h3,designator=4'h1,opcode=4'h5,data=32'hDEADBEEF -> o_config=64'hD0000_3_1_5_DEADBEEF for one cycle, load=1.
REQ-033 Three back-to-back entries with INJECT_GAP=2 -> injections exactly 2 cycles apart, and cfg_ready low in the cycles between them.
REQ-034 x=5 with COLS=4 -> no injection, err_route pulses once, FSM remains in IDLE, load unchanged.
REQ-035 Single entry with cfg_last -> load high for DRAIN_CYCLES=48 cycles after injection, then load=0 with a done pulse in the same cycle.
REQ-036 Reset asserted 10 cycles into DRAIN -> load=0 and o_config=0 immediately, no done pulse, cfg_ready=1 after release.
REQ-037 An illegal entry with cfg_last as the first entry -> err_route and done both pulse, load never rises.
